// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a host-side FIFO and valid/ready handshake.
// Words are queued by the host, then serialised LSB-first onto tx with a start bit,
// optional even/odd parity and one or two stop bits. Frames run back-to-back while
// the FIFO holds data. Frame options are captured when a word leaves the FIFO, so
// the host may change them at any time without corrupting a frame already on the line.
module uart_tx_fifo #(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DATA_W-1:0]                   data_in,
  input  logic                                data_valid,
  output logic                                data_ready,
  input  logic                                parity_en,
  input  logic                                parity_odd,
  input  logic                                two_stop,
  output logic                                tx,
  output logic                                busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_W);

  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  logic [DATA_W-1:0] fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [CNT_W-1:0]  count;

  state_t            state;
  logic [BAUD_W-1:0] baudCnt;
  logic [BIT_W-1:0]  bitCnt;
  logic [DATA_W-1:0] shiftReg;
  logic              parityBit;
  logic              parityOn;
  logic              twoStopOn;

  logic              push;
  logic              pop;
  logic              baudDone;
  logic              stopDone;
  logic [DATA_W-1:0] headWord;
  logic              headParity;

  // In STOP, bitCnt is reused to count stop bits, so the frame ends on the
  // second stop bit only when two stop bits were captured for this frame.
  assign data_ready = (count < DEPTH_C);
  assign push       = data_valid & data_ready;
  assign baudDone   = (baudCnt == BAUD_LAST);
  assign stopDone   = baudDone && (!twoStopOn || (bitCnt == BIT_W'(1)));
  assign pop        = (count != '0) && ((state == IDLE) || ((state == STOP) && stopDone));
  assign headWord   = fifoMem[rdPtr];
  assign headParity = ^headWord;
  assign fifo_count = count;
  assign busy       = (state != IDLE);

  // FIFO storage: written on every accepted handshake, no reset needed for data.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr] <= data_in;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer: loads a word from the FIFO head and walks it out bit by bit,
  // chaining straight into the next start bit when more words are waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      baudCnt   <= '0;
      bitCnt    <= '0;
      shiftReg  <= '0;
      parityBit <= 1'b0;
      parityOn  <= 1'b0;
      twoStopOn <= 1'b0;
    end else if (pop) begin
      shiftReg  <= headWord;
      parityBit <= parity_odd ? ~headParity : headParity;
      parityOn  <= parity_en;
      twoStopOn <= two_stop;
      tx        <= 1'b0;
      baudCnt   <= '0;
      bitCnt    <= '0;
      state     <= START;
    end else begin
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          baudCnt <= '0;
          bitCnt  <= '0;
        end
        START: begin
          if (baudDone) begin
            baudCnt <= '0;
            bitCnt  <= '0;
            tx      <= shiftReg[0];
            state   <= DATA;
          end else begin
            baudCnt <= baudCnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baudDone) begin
            baudCnt <= '0;
            if (bitCnt == BIT_LAST) begin
              bitCnt <= '0;
              if (parityOn) begin
                tx    <= parityBit;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bitCnt   <= bitCnt + BIT_W'(1);
              shiftReg <= shiftReg >> 1;
              tx       <= shiftReg[1];
            end
          end else begin
            baudCnt <= baudCnt + BAUD_W'(1);
          end
        end
        PARITY: begin
          if (baudDone) begin
            baudCnt <= '0;
            bitCnt  <= '0;
            tx      <= 1'b1;
            state   <= STOP;
          end else begin
            baudCnt <= baudCnt + BAUD_W'(1);
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (baudDone) begin
            baudCnt <= '0;
            if (stopDone) begin
              bitCnt <= '0;
              state  <= IDLE;
            end else begin
              bitCnt <= BIT_W'(1);
            end
          end else begin
            baudCnt <= baudCnt + BAUD_W'(1);
          end
        end
        default: begin
          tx      <= 1'b1;
          baudCnt <= '0;
          bitCnt  <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
